// File: rtl/latch_seq_pkg.sv
//------------------------------------------------------------------------------
// latch_seq_pkg : shared types for the latch bank write sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package latch_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        GATE  = 3'd2,
        HOLD  = 3'd3,
        BULK  = 3'd4,
        BGAP  = 3'd5
    } state_e;

    typedef enum logic {
        BK_CLR = 1'b0,
        BK_PRE = 1'b1
    } bulk_kind_e;

    // Down-counter must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/latch_bank_sequencer_if.sv
//------------------------------------------------------------------------------
// latch_bank_sequencer_if : requester handshakes, bulk commands and latch pins
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface latch_bank_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [AW-1:0]    req0_addr;
    logic [WIDTH-1:0] req0_data;
    logic             req1_valid;
    logic             req1_ready;
    logic [AW-1:0]    req1_addr;
    logic [WIDTH-1:0] req1_data;
    logic             clr_req;
    logic             pre_req;
    logic [WIDTH-1:0] lat_d;
    logic [DEPTH-1:0] lat_ge;
    logic             lat_g;
    logic             lat_clr;
    logic             lat_pre;
    logic             busy;
    logic             err;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output clr_req, pre_req,
        input  req0_ready, req1_ready,
        input  lat_d, lat_ge, lat_g, lat_clr, lat_pre, busy, err
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  clr_req, pre_req,
        output req0_ready, req1_ready,
        output lat_d, lat_ge, lat_g, lat_clr, lat_pre, busy, err
    );

endinterface

`default_nettype wire

// File: rtl/latch_bank_sequencer_rr_arb2.sv
//------------------------------------------------------------------------------
// rr_arb2 : two-way round-robin arbiter, pointer moves only on a transfer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
    input  logic clk,
    input  logic reset_n,
    input  logic valid0,
    input  logic valid1,
    input  logic advance,
    output logic grant0,
    output logic grant1
);

    // High when requester 1 was served most recently; reset favours requester 0.
    logic last1_q;
    logic last1_d;

    always_comb begin
        grant0  = valid0 && (!valid1 || last1_q);
        grant1  = valid1 && (!valid0 || !last1_q);
        last1_d = advance ? grant1 : last1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last1_q <= 1'b1;
        end else begin
            last1_q <= last1_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/latch_bank_sequencer.sv
//------------------------------------------------------------------------------
// latch_bank_sequencer : arbitrated write/clear/preset sequencer for a latch bank
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module latch_bank_sequencer
    import latch_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int GATE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    latch_bank_sequencer_if.slave  bus
);

    localparam int                 c_cnt_w     = cnt_width(GATE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_gate_load = c_cnt_w'(GATE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

    state_e             state_q, state_d;
    bulk_kind_e         kind_q, kind_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               clr_pend_q, clr_pend_d;
    logic               pre_pend_q, pre_pend_d;
    logic [WIDTH-1:0]   lat_d_q, lat_d_d;
    logic [DEPTH-1:0]   lat_ge_q, lat_ge_d;
    logic               lat_g_q, lat_g_d;
    logic               lat_clr_q, lat_clr_d;
    logic               lat_pre_q, lat_pre_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               grant0, grant1;
    logic               idle_free;
    logic               accept;
    logic [AW-1:0]      sel_addr;
    logic [WIDTH-1:0]   sel_data;
    logic [DEPTH-1:0]   sel_onehot;
    logic               addr_bad;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .valid0  (bus.req0_valid),
        .valid1  (bus.req1_valid),
        .advance (accept),
        .grant0  (grant0),
        .grant1  (grant1)
    );

    // Pending bulk ops block new writes, so they win over both requesters.
    assign idle_free      = reset_n && (state_q == IDLE) && !clr_pend_q && !pre_pend_q;
    assign bus.req0_ready = idle_free && grant0;
    assign bus.req1_ready = idle_free && grant1;
    assign accept         = idle_free && (grant0 || grant1);

    assign sel_addr = grant1 ? bus.req1_addr : bus.req0_addr;
    assign sel_data = grant1 ? bus.req1_data : bus.req0_data;
    assign addr_bad = int'(sel_addr) >= DEPTH;

    // Out-of-range addresses match no entry, leaving the enables all zero.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_addr == AW'(i)) begin
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        cnt_d      = cnt_q;
        lat_d_d    = lat_d_q;
        lat_ge_d   = lat_ge_q;
        lat_g_d    = 1'b1;
        lat_clr_d  = 1'b0;
        lat_pre_d  = 1'b0;
        err_d      = 1'b0;
        clr_pend_d = clr_pend_q || bus.clr_req;
        pre_pend_d = pre_pend_q || bus.pre_req;

        case (state_q)
            IDLE: begin
                if (clr_pend_q) begin
                    state_d   = BULK;
                    kind_d    = BK_CLR;
                    cnt_d     = c_gate_load;
                    lat_ge_d  = '0;
                    lat_clr_d = 1'b1;
                end else if (pre_pend_q) begin
                    state_d   = BULK;
                    kind_d    = BK_PRE;
                    cnt_d     = c_gate_load;
                    lat_ge_d  = '0;
                    lat_pre_d = 1'b1;
                end else if (accept) begin
                    state_d  = SETUP;
                    lat_d_d  = sel_data;
                    lat_ge_d = sel_onehot;
                    err_d    = addr_bad;
                end
            end
            SETUP: begin
                state_d = GATE;
                cnt_d   = c_gate_load;
                lat_g_d = 1'b0;
            end
            GATE: begin
                if (cnt_q == c_one) begin
                    state_d = HOLD;
                end else begin
                    cnt_d   = cnt_q - c_one;
                    lat_g_d = 1'b0;
                end
            end
            HOLD: begin
                state_d  = IDLE;
                lat_ge_d = '0;
            end
            BULK: begin
                if (cnt_q == c_one) begin
                    state_d = BGAP;
                end else begin
                    cnt_d     = cnt_q - c_one;
                    lat_clr_d = (kind_q == BK_CLR);
                    lat_pre_d = (kind_q == BK_PRE);
                end
            end
            BGAP: begin
                state_d = IDLE;
                if (kind_q == BK_CLR) begin
                    clr_pend_d = bus.clr_req;
                end else begin
                    pre_pend_d = bus.pre_req;
                end
            end
            default: begin
                state_d  = IDLE;
                lat_ge_d = '0;
            end
        endcase

        busy_d = (state_d != IDLE) || clr_pend_d || pre_pend_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            kind_q     <= BK_CLR;
            cnt_q      <= '0;
            clr_pend_q <= 1'b0;
            pre_pend_q <= 1'b0;
            lat_d_q    <= '0;
            lat_ge_q   <= '0;
            lat_g_q    <= 1'b1;
            lat_clr_q  <= 1'b0;
            lat_pre_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            cnt_q      <= cnt_d;
            clr_pend_q <= clr_pend_d;
            pre_pend_q <= pre_pend_d;
            lat_d_q    <= lat_d_d;
            lat_ge_q   <= lat_ge_d;
            lat_g_q    <= lat_g_d;
            lat_clr_q  <= lat_clr_d;
            lat_pre_q  <= lat_pre_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.lat_d   = lat_d_q;
    assign bus.lat_ge  = lat_ge_q;
    assign bus.lat_g   = lat_g_q;
    assign bus.lat_clr = lat_clr_q;
    assign bus.lat_pre = lat_pre_q;
    assign bus.busy    = busy_q;
    assign bus.err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_latch_bank_sequencer.sv
//------------------------------------------------------------------------------
// tb_latch_bank_sequencer : directed scenarios plus a randomized run against a
// transaction-timeline reference model. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_latch_bank_sequencer;

    localparam int N   = 2;
    localparam int DEP = 6;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    latch_bank_sequencer_if #(.WIDTH(8), .DEPTH(DEP), .AW(3)) bus ();
    latch_bank_sequencer_if #(.WIDTH(8), .DEPTH(8),   .AW(3)) bus1 ();

    latch_bank_sequencer #(.WIDTH(8), .DEPTH(DEP), .AW(3), .GATE_CYCLES(N)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    latch_bank_sequencer #(.WIDTH(8), .DEPTH(8), .AW(3), .GATE_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    task automatic drive_idle();
        bus.req0_valid = 0; bus.req0_addr = 0; bus.req0_data = 0;
        bus.req1_valid = 0; bus.req1_addr = 0; bus.req1_data = 0;
        bus.clr_req = 0; bus.pre_req = 0;
        bus1.req0_valid = 0; bus1.req0_addr = 0; bus1.req0_data = 0;
        bus1.req1_valid = 0; bus1.req1_addr = 0; bus1.req1_data = 0;
        bus1.clr_req = 0; bus1.pre_req = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [19:0] got;
        drive_idle();
        #1 reset_n = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        got = {bus.lat_d, bus.lat_ge, bus.lat_g, bus.lat_clr, bus.lat_pre, bus.busy, bus.err, bus.req0_ready};
        n_tests++;
        if (got !== {8'h00, 6'h00, 1'b1, 5'b00000}) begin
            n_fail++; $display("FAIL reset_state got=%h expected=%h", got, {8'h00, 6'h00, 1'b1, 5'b00000});
        end
        tick(); tick();
        bus.req0_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        n_tests++;
        if ({bus.busy, bus.lat_g, bus1.lat_g, bus1.lat_ge} !== {1'b0, 1'b1, 1'b1, 8'h00}) begin
            n_fail++; $display("FAIL reset_release got=%b expected=%b",
                {bus.busy, bus.lat_g, bus1.lat_g, bus1.lat_ge}, {1'b0, 1'b1, 1'b1, 8'h00});
        end
    endtask

    // addr 3, data 0xA5: enable in cycles 1-4, gate open in 2-3, idle at 5.
    task automatic test_single_write();
        logic [16:0] got, exp;
        bus.req0_valid = 1; bus.req0_addr = 3'd3; bus.req0_data = 8'hA5;
        #1;
        n_tests++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            n_fail++; $display("FAIL single_ready got=%b expected=10", {bus.req0_ready, bus.req1_ready});
        end
        tick();
        bus.req0_valid = 0;
        for (int c = 1; c <= 6; c++) begin
            exp = {8'hA5, (c <= 4) ? 6'h08 : 6'h00, !(c == 2 || c == 3), c <= 4, 1'b0};
            got = {bus.lat_d, bus.lat_ge, bus.lat_g, bus.busy, bus.err};
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL single_write cyc=%0d got=%h expected=%h", c, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_bad_addr();
        logic [16:0] got, exp;
        bus.req0_valid = 1; bus.req0_addr = 3'd7; bus.req0_data = 8'h5A;
        tick();
        bus.req0_valid = 0;
        for (int c = 1; c <= 5; c++) begin
            exp = {8'h5A, 6'h00, !(c == 2 || c == 3), c <= 4, c == 1};
            got = {bus.lat_d, bus.lat_ge, bus.lat_g, bus.busy, bus.err};
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL bad_addr cyc=%0d got=%h expected=%h", c, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_bulk_during_write();
        logic [2:0] got, exp;
        bus.req0_valid = 1; bus.req0_addr = 3'd1; bus.req0_data = 8'h3C;
        tick();
        bus.req0_valid = 0;
        bus.req1_valid = 1; bus.req1_addr = 3'd4; bus.req1_data = 8'h96;
        for (int c = 1; c <= 13; c++) begin
            bus.clr_req = (c == 2);
            bus.pre_req = (c == 2);
            #1;
            exp = {c == 6 || c == 7, c == 10 || c == 11, c == 13};
            got = {bus.lat_clr, bus.lat_pre, bus.req1_ready};
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL bulk_strobes cyc=%0d got=%b expected=%b", c, got, exp);
            end
            if (c >= 5) begin
                n_tests++;
                if ({bus.lat_g, bus.lat_ge} !== {1'b1, 6'h00}) begin
                    n_fail++; $display("FAIL bulk_gate cyc=%0d got=%b expected=1000000", c, {bus.lat_g, bus.lat_ge});
                end
            end
            tick();
        end
        bus.clr_req = 0; bus.pre_req = 0; bus.req1_valid = 0;
        n_tests++;
        if ({bus.lat_d, bus.lat_ge} !== {8'h96, 6'h10}) begin
            n_fail++; $display("FAIL bulk_deferred_write got=%h expected=%h", {bus.lat_d, bus.lat_ge}, {8'h96, 6'h10});
        end
        repeat (5) tick();
    endtask

    task automatic test_async_reset();
        bus.req0_valid = 1; bus.req0_addr = 3'd2; bus.req0_data = 8'h77;
        tick();
        bus.req0_valid = 0;
        tick();
        n_tests++;
        if ({bus.lat_g, bus.lat_ge} !== {1'b0, 6'h04}) begin
            n_fail++; $display("FAIL areset_pre got=%b expected=0000100", {bus.lat_g, bus.lat_ge});
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.lat_g, bus.lat_ge, bus.lat_d, bus.busy} !== {1'b1, 6'h00, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL areset_immediate got=%h expected=%h",
                {bus.lat_g, bus.lat_ge, bus.lat_d, bus.busy}, {1'b1, 6'h00, 8'h00, 1'b0});
        end
        tick(); tick();
        reset_n = 1'b1;
        tick();
        bus.req0_valid = 1; bus.req1_valid = 1;
        #1;
        n_tests++;
        if ({bus.busy, bus.lat_g, bus.req0_ready, bus.req1_ready} !== 4'b0110) begin
            n_fail++; $display("FAIL areset_after got=%b expected=0110",
                {bus.busy, bus.lat_g, bus.req0_ready, bus.req1_ready});
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        tick();
    endtask

    task automatic test_round_robin();
        bit acc;
        int gsel;
        bus.req0_valid = 1; bus.req0_addr = 3'd0; bus.req0_data = 8'h11;
        bus.req1_valid = 1; bus.req1_addr = 3'd5; bus.req1_data = 8'h22;
        #1;
        for (int c = 0; c < 20; c++) begin
            acc  = (c % 5 == 0);
            gsel = (c / 5) % 2;
            n_tests++;
            if ({bus.req0_ready, bus.req1_ready} !== {acc && gsel == 0, acc && gsel == 1}) begin
                n_fail++; $display("FAIL rr_grant cyc=%0d got=%b expected=%b", c,
                    {bus.req0_ready, bus.req1_ready}, {acc && gsel == 0, acc && gsel == 1});
            end
            if (c % 5 == 1) begin
                n_tests++;
                if (bus.lat_d !== ((gsel == 0) ? 8'h11 : 8'h22)) begin
                    n_fail++; $display("FAIL rr_data cyc=%0d got=%h expected=%h", c, bus.lat_d,
                        (gsel == 0) ? 8'h11 : 8'h22);
                end
            end
            tick();
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        repeat (2) tick();
    endtask

    task automatic test_gate1();
        logic [10:0] got, exp;
        bus1.req0_valid = 1; bus1.req0_addr = 3'd7; bus1.req0_data = 8'hC3;
        #1;
        for (int c = 0; c <= 8; c++) begin
            exp = {c % 4 == 0, !(c % 4 == 2), (c % 4 != 0) ? 8'h80 : 8'h00, 1'b0};
            got = {bus1.req0_ready, bus1.lat_g, bus1.lat_ge, bus1.err};
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL gate1 cyc=%0d got=%h expected=%h", c, got, exp);
            end
            tick();
        end
        bus1.req0_valid = 0;
        repeat (4) tick();
    endtask

    // Reference model: each operation is a start cycle plus a kind; pin
    // values are a pure function of the offset from that start.
    task automatic test_random();
        int          op, start, k, cyc;
        logic [2:0]  m_addr, a0, a1;
        logic [7:0]  e_d, d0, d1;
        logic [5:0]  e_ge;
        logic [18:0] got, exp;
        bit          pc, pp, last1, idle, rdy0, rdy1, v0, v1, cr, pr;
        drive_idle();
        reset_n = 1'b0; tick(); tick();
        reset_n = 1'b1; tick();
        op = 0; start = 0; cyc = 0; e_d = 0; m_addr = 0;
        pc = 0; pp = 0; last1 = 1;
        repeat (800) begin
            k    = cyc - start;
            idle = (op == 0) || (op == 1 && k >= N + 3) || (op >= 2 && k >= N + 2);
            if (idle) op = 0;
            e_ge = (op == 1 && k <= N + 2 && int'(m_addr) < DEP) ? 6'(1 << m_addr) : 6'd0;
            exp  = {e_d, e_ge, !(op == 1 && k >= 2 && k <= N + 1), op == 2 && k <= N, op == 3 && k <= N,
                    !idle || pc || pp, op == 1 && k == 1 && int'(m_addr) >= DEP};
            got  = {bus.lat_d, bus.lat_ge, bus.lat_g, bus.lat_clr, bus.lat_pre, bus.busy, bus.err};
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL random_outputs cyc=%0d got=%h expected=%h", cyc, got, exp);
            end
            v0 = $urandom_range(0, 99) < 45;
            v1 = $urandom_range(0, 99) < 45;
            cr = $urandom_range(0, 99) < 4;
            pr = $urandom_range(0, 99) < 4;
            if (op >= 2 && k == N + 1) begin
                cr = 0; pr = 0;
            end
            a0 = 3'($urandom_range(0, 7)); d0 = 8'($urandom);
            a1 = 3'($urandom_range(0, 7)); d1 = 8'($urandom);
            bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
            bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
            bus.clr_req = cr; bus.pre_req = pr;
            #1;
            rdy0 = idle && !pc && !pp && v0 && (!v1 || last1);
            rdy1 = idle && !pc && !pp && v1 && (!v0 || !last1);
            n_tests++;
            if ({bus.req0_ready, bus.req1_ready} !== {rdy0, rdy1}) begin
                n_fail++; $display("FAIL random_ready cyc=%0d got=%b expected=%b", cyc,
                    {bus.req0_ready, bus.req1_ready}, {rdy0, rdy1});
            end
            if (op == 2 && k == N + 1) pc = 0;
            if (op == 3 && k == N + 1) pp = 0;
            if (idle) begin
                if (pc) begin
                    op = 2; start = cyc;
                end else if (pp) begin
                    op = 3; start = cyc;
                end else if (rdy0) begin
                    op = 1; start = cyc; m_addr = a0; e_d = d0; last1 = 0;
                end else if (rdy1) begin
                    op = 1; start = cyc; m_addr = a1; e_d = d1; last1 = 1;
                end
            end
            pc = pc || cr;
            pp = pp || pr;
            tick();
            cyc++;
        end
        drive_idle();
        repeat (6) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_bad_addr();
        test_bulk_during_write();
        test_async_reset();
        test_round_robin();
        test_gate1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
